// File: rtl/sync_wconv_fifo_if.sv
// Handshake/data bundle for sync_wconv_fifo.
//   flush_i                         synchronous clear request
//   data_i, wr_valid_i              write word and write request
//   wr_ready_o, full_o              room for one write word / its inverse
//   data_o, rd_valid_i              head read word (fall-through) and pop request
//   rd_ready_o, empty_o             one read word available / its inverse
//   almost_full_o, almost_empty_o   programmable occupancy thresholds
//   count_o                         occupancy in granules
// The master modport is the side that drives the requests (producer/consumer
// logic or a testbench); the FIFO itself uses the slave modport.
interface sync_wconv_fifo_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8,
  parameter int CW    = 5
);
  logic             flush_i;
  logic [IN_W-1:0]  data_i;
  logic             wr_valid_i;
  logic             wr_ready_o;
  logic             full_o;
  logic [OUT_W-1:0] data_o;
  logic             rd_valid_i;
  logic             rd_ready_o;
  logic             empty_o;
  logic             almost_full_o;
  logic             almost_empty_o;
  logic [CW-1:0]    count_o;

  modport master (
    output flush_i, data_i, wr_valid_i, rd_valid_i,
    input  wr_ready_o, full_o, data_o, rd_ready_o, empty_o,
           almost_full_o, almost_empty_o, count_o
  );

  modport slave (
    input  flush_i, data_i, wr_valid_i, rd_valid_i,
    output wr_ready_o, full_o, data_o, rd_ready_o, empty_o,
           almost_full_o, almost_empty_o, count_o
  );
endinterface

// File: rtl/sync_wconv_fifo.sv
// Synchronous FIFO with independent write and read widths (upsize, downsize
// or equal). Storage is a ring of CAP granules, a granule being the narrower
// of the two widths. A write stores WG granules, a read consumes RG granules.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (pointers only; memory is not reset)
//   bus    sync_wconv_fifo_if.slave: write/read handshakes, flush, status
// Parameters:
//   IN_DATA_WIDTH / OUT_DATA_WIDTH  word widths, ratio a power of 2
//   FIFO_DEPTH                      capacity in wide words, power of 2, >= 2
//   ORDER                           "LSB" or "MSB": where the earliest granule
//                                   sits inside the wide word
//   AF_LEVEL / AE_LEVEL             almost-full / almost-empty thresholds in granules
module sync_wconv_fifo #(
  parameter int IN_DATA_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter     ORDER          = "LSB",
  parameter int AF_LEVEL       = FIFO_DEPTH *
                                 ((IN_DATA_WIDTH > OUT_DATA_WIDTH) ?
                                  IN_DATA_WIDTH / OUT_DATA_WIDTH :
                                  OUT_DATA_WIDTH / IN_DATA_WIDTH) - 1,
  parameter int AE_LEVEL       = 1
) (
  input logic            clk,
  input logic            rst_n,
  sync_wconv_fifo_if.slave bus
);
  localparam int G    = (IN_DATA_WIDTH < OUT_DATA_WIDTH) ? IN_DATA_WIDTH : OUT_DATA_WIDTH;
  localparam int WG   = IN_DATA_WIDTH / G;
  localparam int RG   = OUT_DATA_WIDTH / G;
  localparam int MAXG = (WG > RG) ? WG : RG;
  localparam int CAP  = FIFO_DEPTH * MAXG;
  localparam int AW   = $clog2(CAP);
  localparam int CW   = AW + 1;
  localparam bit MSB_FIRST = (ORDER == "MSB");

  localparam logic [CW-1:0] CAP_CW = CW'(CAP);
  localparam logic [CW-1:0] WG_CW  = CW'(WG);
  localparam logic [CW-1:0] RG_CW  = CW'(RG);
  localparam logic [CW-1:0] AF_CW  = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CW  = CW'(AE_LEVEL);

  genvar gi;

  // Elaboration-time parameter legality checks.
  generate
    if ((IN_DATA_WIDTH % G) != 0 || (OUT_DATA_WIDTH % G) != 0 ||
        (WG & (WG - 1)) != 0 || (RG & (RG - 1)) != 0) begin : g_bad_ratio
      $error("sync_wconv_fifo: width ratio must be a power of 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_wconv_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (ORDER != "LSB" && ORDER != "MSB") begin : g_bad_order
      $error("sync_wconv_fifo: ORDER must be \"LSB\" or \"MSB\"");
    end
  endgenerate

  // Pointers count granules; the extra MSB is the wrap bit, so the natural
  // CW-bit overflow gives the required mod-2*CAP wrap.
  logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          wr_ready;
  logic          rd_ready;
  logic          wr_fire;
  logic          rd_fire;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  // Register-based ring: the head word must be visible combinationally
  // (first-word fall-through), so there is no registered read here.
  logic [G-1:0]              mem [CAP];
  logic [G-1:0]              wr_gran [WG];
  logic [OUT_DATA_WIDTH-1:0] rd_data;

  assign count    = wr_ptr_reg - rd_ptr_reg;
  assign free     = CAP_CW - count;
  assign wr_ready = (free >= WG_CW);
  assign rd_ready = (count >= RG_CW);

  // Flush suppresses both handshakes so neither touches memory or pointers.
  assign wr_fire  = bus.wr_valid_i & wr_ready & ~bus.flush_i;
  assign rd_fire  = bus.rd_valid_i & rd_ready & ~bus.flush_i;

  assign wr_idx   = wr_ptr_reg[AW-1:0];
  assign rd_idx   = rd_ptr_reg[AW-1:0];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (bus.flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_fire) wr_ptr_next = wr_ptr_reg + WG_CW;
      if (rd_fire) rd_ptr_next = rd_ptr_reg + RG_CW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Split the write word into granules in arrival order. Pointers are always
  // multiples of WG/RG and CAP is a multiple of both, so a word never
  // straddles the end of the ring and idx+k needs no wrap handling.
  generate
    for (gi = 0; gi < WG; gi++) begin : g_wr_gran
      localparam int SLOT = MSB_FIRST ? (WG - 1 - gi) : gi;
      assign wr_gran[gi] = bus.data_i[G*SLOT +: G];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int k = 0; k < WG; k++) begin
        mem[wr_idx + AW'(k)] <= wr_gran[k];
      end
    end
  end

  // Assemble the read word from the RG granules at the head.
  generate
    for (gi = 0; gi < RG; gi++) begin : g_rd_gran
      localparam int SLOT = MSB_FIRST ? (RG - 1 - gi) : gi;
      assign rd_data[G*SLOT +: G] = mem[rd_idx + AW'(gi)];
    end
  endgenerate

  assign bus.wr_ready_o     = wr_ready;
  assign bus.full_o         = ~wr_ready;
  assign bus.rd_ready_o     = rd_ready;
  assign bus.empty_o        = ~rd_ready;
  assign bus.data_o         = rd_data;
  assign bus.count_o        = count;
  assign bus.almost_full_o  = (count >= AF_CW);
  assign bus.almost_empty_o = (count <= AE_CW);
endmodule

// File: tb/tb_sync_wconv_fifo.sv
`timescale 1ns/1ps
module tb_sync_wconv_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // dn: 32->8 LSB, dm: 32->8 MSB, up: 8->32 LSB, eq: 16->16
  sync_wconv_fifo_if #(.IN_W(32), .OUT_W(8),  .CW(5)) if_dn ();
  sync_wconv_fifo_if #(.IN_W(32), .OUT_W(8),  .CW(5)) if_dm ();
  sync_wconv_fifo_if #(.IN_W(8),  .OUT_W(32), .CW(5)) if_up ();
  sync_wconv_fifo_if #(.IN_W(16), .OUT_W(16), .CW(3)) if_eq ();

  sync_wconv_fifo #(.IN_DATA_WIDTH(32), .OUT_DATA_WIDTH(8), .FIFO_DEPTH(4), .ORDER("LSB"))
    u_dn (.clk(clk), .rst_n(rst_n), .bus(if_dn));
  sync_wconv_fifo #(.IN_DATA_WIDTH(32), .OUT_DATA_WIDTH(8), .FIFO_DEPTH(4), .ORDER("MSB"))
    u_dm (.clk(clk), .rst_n(rst_n), .bus(if_dm));
  sync_wconv_fifo #(.IN_DATA_WIDTH(8), .OUT_DATA_WIDTH(32), .FIFO_DEPTH(4), .ORDER("LSB"))
    u_up (.clk(clk), .rst_n(rst_n), .bus(if_up));
  sync_wconv_fifo #(.IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(16), .FIFO_DEPTH(4), .ORDER("LSB"))
    u_eq (.clk(clk), .rst_n(rst_n), .bus(if_eq));

  // Packed status: {wr_ready, full, rd_ready, empty, almost_full, almost_empty, count}
  logic [10:0] st_dn, st_dm, st_up, st_eq;
  assign st_dn = {if_dn.wr_ready_o, if_dn.full_o, if_dn.rd_ready_o, if_dn.empty_o,
                  if_dn.almost_full_o, if_dn.almost_empty_o, if_dn.count_o};
  assign st_dm = {if_dm.wr_ready_o, if_dm.full_o, if_dm.rd_ready_o, if_dm.empty_o,
                  if_dm.almost_full_o, if_dm.almost_empty_o, if_dm.count_o};
  assign st_up = {if_up.wr_ready_o, if_up.full_o, if_up.rd_ready_o, if_up.empty_o,
                  if_up.almost_full_o, if_up.almost_empty_o, if_up.count_o};
  assign st_eq = {if_eq.wr_ready_o, if_eq.full_o, if_eq.rd_ready_o, if_eq.empty_o,
                  if_eq.almost_full_o, if_eq.almost_empty_o, 2'b00, if_eq.count_o};

  // Reference models: queues of granules in arrival order.
  logic [7:0]  q_dn[$];
  logic [7:0]  q_dm[$];
  logic [7:0]  q_up[$];
  logic [15:0] q_eq[$];

  // Expected status from occupancy alone.
  function automatic logic [10:0] exp_st(int cnt, int cap, int wg, int rg, int af, int ae);
    logic wr, rr;
    wr = ((cap - cnt) >= wg);
    rr = (cnt >= rg);
    return {wr, ~wr, rr, ~rr, logic'(cnt >= af), logic'(cnt <= ae), 5'(cnt)};
  endfunction

  task automatic idle_all();
    if_dn.flush_i = 0; if_dn.wr_valid_i = 0; if_dn.rd_valid_i = 0; if_dn.data_i = '0;
    if_dm.flush_i = 0; if_dm.wr_valid_i = 0; if_dm.rd_valid_i = 0; if_dm.data_i = '0;
    if_up.flush_i = 0; if_up.wr_valid_i = 0; if_up.rd_valid_i = 0; if_up.data_i = '0;
    if_eq.flush_i = 0; if_eq.wr_valid_i = 0; if_eq.rd_valid_i = 0; if_eq.data_i = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (st_dn !== exp_st(0, 16, 4, 1, 15, 1)) begin bad++;
      $display("FAIL reset_dn got=%h exp=%h", st_dn, exp_st(0, 16, 4, 1, 15, 1)); end
    total++; if (st_up !== exp_st(0, 16, 1, 4, 15, 1)) begin bad++;
      $display("FAIL reset_up got=%h exp=%h", st_up, exp_st(0, 16, 1, 4, 15, 1)); end
    total++; if (st_eq !== exp_st(0, 4, 1, 1, 3, 1)) begin bad++;
      $display("FAIL reset_eq got=%h exp=%h", st_eq, exp_st(0, 4, 1, 1, 3, 1)); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (st_dm !== exp_st(0, 16, 4, 1, 15, 1)) begin bad++;
      $display("FAIL reset_dm_released got=%h exp=%h", st_dm, exp_st(0, 16, 4, 1, 15, 1)); end
    $display("reset released");
  endtask

  // Downsize, LSB and MSB ordering side by side.
  task automatic test_downsize();
    logic [7:0] lsb_seq [4];
    logic [7:0] msb_seq [4];
    lsb_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    msb_seq = '{8'h44, 8'h33, 8'h22, 8'h11};
    @(negedge clk);
    if_dn.data_i = 32'h44332211; if_dn.wr_valid_i = 1;
    if_dm.data_i = 32'h44332211; if_dm.wr_valid_i = 1;
    $display("downsize write 44332211");
    @(negedge clk);
    if_dn.wr_valid_i = 0; if_dm.wr_valid_i = 0;
    if_dn.rd_valid_i = 1; if_dm.rd_valid_i = 1;
    for (int i = 0; i < 4; i++) begin
      total++; if ({if_dn.rd_ready_o, if_dn.data_o} !== {1'b1, lsb_seq[i]}) begin bad++;
        $display("FAIL down_lsb_%0d got=%b/%h exp=1/%h", i, if_dn.rd_ready_o, if_dn.data_o, lsb_seq[i]); end
      total++; if ({if_dm.rd_ready_o, if_dm.data_o} !== {1'b1, msb_seq[i]}) begin bad++;
        $display("FAIL down_msb_%0d got=%b/%h exp=1/%h", i, if_dm.rd_ready_o, if_dm.data_o, msb_seq[i]); end
      $display("downsize read %0d lsb=%h msb=%h", i, if_dn.data_o, if_dm.data_o);
      @(negedge clk);
    end
    if_dn.rd_valid_i = 0; if_dm.rd_valid_i = 0;
    total++; if ({if_dn.empty_o, if_dm.empty_o} !== 2'b11) begin bad++;
      $display("FAIL down_empty got=%b%b exp=11", if_dn.empty_o, if_dm.empty_o); end
  endtask

  task automatic test_upsize();
    logic [7:0] bytes [4];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if_up.data_i = bytes[i]; if_up.wr_valid_i = 1;
      $display("upsize write %h", bytes[i]);
    end
    @(negedge clk);
    if_up.wr_valid_i = 0;
    total++; if (st_up !== exp_st(3, 16, 1, 4, 15, 1)) begin bad++;
      $display("FAIL up_partial got=%h exp=%h", st_up, exp_st(3, 16, 1, 4, 15, 1)); end
    if_up.data_i = bytes[3]; if_up.wr_valid_i = 1;
    $display("upsize write %h", bytes[3]);
    @(negedge clk);
    if_up.wr_valid_i = 0;
    total++; if ({if_up.rd_ready_o, if_up.data_o} !== {1'b1, 32'h44332211}) begin bad++;
      $display("FAIL up_word got=%b/%h exp=1/44332211", if_up.rd_ready_o, if_up.data_o); end
    if_up.rd_valid_i = 1;
    $display("upsize read %h", if_up.data_o);
    @(negedge clk);
    if_up.rd_valid_i = 0;
    total++; if (st_up !== exp_st(0, 16, 1, 4, 15, 1)) begin bad++;
      $display("FAIL up_drained got=%h exp=%h", st_up, exp_st(0, 16, 1, 4, 15, 1)); end
  endtask

  task automatic test_full();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w = $urandom;
      if_dn.data_i = w; if_dn.wr_valid_i = 1;
      for (int k = 0; k < 4; k++) q_dn.push_back(w[8*k +: 8]);
      $display("full write %h", w);
    end
    @(negedge clk);
    total++; if (st_dn !== exp_st(16, 16, 4, 1, 15, 1)) begin bad++;
      $display("FAIL full_16 got=%h exp=%h", st_dn, exp_st(16, 16, 4, 1, 15, 1)); end
    if_dn.data_i = 32'hdeadbeef;   // stays requested: must be ignored
    @(negedge clk);
    total++; if ({st_dn, if_dn.data_o} !== {exp_st(16, 16, 4, 1, 15, 1), q_dn[0]}) begin bad++;
      $display("FAIL full_5th_write got=%h/%h exp=%h/%h", st_dn, if_dn.data_o,
               exp_st(16, 16, 4, 1, 15, 1), q_dn[0]); end
    // Read while full and still requesting a write: the write is refused.
    if_dn.rd_valid_i = 1;
    void'(q_dn.pop_front());
    @(negedge clk);
    if_dn.wr_valid_i = 0;
    total++; if (st_dn !== exp_st(15, 16, 4, 1, 15, 1)) begin bad++;
      $display("FAIL full_read1 got=%h exp=%h", st_dn, exp_st(15, 16, 4, 1, 15, 1)); end
    while (q_dn.size() > 0) begin
      total++; if (if_dn.data_o !== q_dn[0]) begin bad++;
        $display("FAIL full_drain got=%h exp=%h", if_dn.data_o, q_dn[0]); end
      $display("full read %h left=%0d", if_dn.data_o, q_dn.size() - 1);
      void'(q_dn.pop_front());
      @(negedge clk);
      if (q_dn.size() == 12) begin
        total++; if (st_dn !== exp_st(12, 16, 4, 1, 15, 1)) begin bad++;
          $display("FAIL full_after4 got=%h exp=%h", st_dn, exp_st(12, 16, 4, 1, 15, 1)); end
      end
    end
    if_dn.rd_valid_i = 0;
    total++; if (st_dn !== exp_st(0, 16, 4, 1, 15, 1)) begin bad++;
      $display("FAIL full_empty got=%h exp=%h", st_dn, exp_st(0, 16, 4, 1, 15, 1)); end
  endtask

  // Empty + simultaneous write/read, then flush overriding both handshakes.
  task automatic test_flush();
    logic [31:0] w;
    @(negedge clk);
    w = $urandom;
    if_dn.data_i = w; if_dn.wr_valid_i = 1; if_dn.rd_valid_i = 1;
    for (int k = 0; k < 4; k++) q_dn.push_back(w[8*k +: 8]);
    $display("flush-test write %h with read on empty", w);
    @(negedge clk);
    if_dn.rd_valid_i = 0;
    total++; if ({st_dn, if_dn.data_o} !== {exp_st(4, 16, 4, 1, 15, 1), q_dn[0]}) begin bad++;
      $display("FAIL empty_no_bypass got=%h/%h exp=%h/%h", st_dn, if_dn.data_o,
               exp_st(4, 16, 4, 1, 15, 1), q_dn[0]); end
    w = $urandom;
    if_dn.data_i = w;
    $display("flush-test write %h", w);
    @(negedge clk);
    total++; if (st_dn !== exp_st(8, 16, 4, 1, 15, 1)) begin bad++;
      $display("FAIL flush_pre got=%h exp=%h", st_dn, exp_st(8, 16, 4, 1, 15, 1)); end
    if_dn.flush_i = 1; if_dn.rd_valid_i = 1; if_dn.data_i = 32'hcafef00d;
    q_dn.delete();
    $display("flush with write and read requested");
    @(negedge clk);
    if_dn.flush_i = 0; if_dn.wr_valid_i = 0; if_dn.rd_valid_i = 0;
    total++; if (st_dn !== exp_st(0, 16, 4, 1, 15, 1)) begin bad++;
      $display("FAIL flush_post got=%h exp=%h", st_dn, exp_st(0, 16, 4, 1, 15, 1)); end
    if_dn.data_i = 32'h0a0b0c0d; if_dn.wr_valid_i = 1;
    @(negedge clk);
    if_dn.wr_valid_i = 0;
    total++; if ({st_dn, if_dn.data_o} !== {exp_st(4, 16, 4, 1, 15, 1), 8'h0d}) begin bad++;
      $display("FAIL flush_restart got=%h/%h exp=%h/0d", st_dn, if_dn.data_o,
               exp_st(4, 16, 4, 1, 15, 1)); end
    for (int k = 0; k < 4; k++) q_dn.push_back(8'h0d + 8'(k) * 8'hff);  // 0d,0c,0b,0a
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    if_up.data_i = 8'h5a; if_up.wr_valid_i = 1;
    repeat (5) @(negedge clk);
    if_up.wr_valid_i = 0;
    total++; if (st_dn !== exp_st(4, 16, 4, 1, 15, 1) || st_up !== exp_st(5, 16, 1, 4, 15, 1)) begin bad++;
      $display("FAIL areset_pre got=%h/%h", st_dn, st_up); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (st_dn !== exp_st(0, 16, 4, 1, 15, 1)) begin bad++;
      $display("FAIL areset_dn got=%h exp=%h", st_dn, exp_st(0, 16, 4, 1, 15, 1)); end
    total++; if (st_up !== exp_st(0, 16, 1, 4, 15, 1)) begin bad++;
      $display("FAIL areset_up got=%h exp=%h", st_up, exp_st(0, 16, 1, 4, 15, 1)); end
    $display("async reset asserted mid-cycle");
    q_dn.delete(); q_dm.delete(); q_up.delete(); q_eq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Equal widths: constant-occupancy streaming that wraps the ring many times.
  task automatic test_wrap_equal();
    logic [15:0] w;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      w = 16'($urandom);
      if_eq.data_i = w; if_eq.wr_valid_i = 1; q_eq.push_back(w);
    end
    @(negedge clk);
    if_eq.rd_valid_i = 1;
    for (int i = 0; i < 20; i++) begin
      total++; if ({st_eq, if_eq.data_o} !== {exp_st(2, 4, 1, 1, 3, 1), q_eq[0]}) begin bad++;
        $display("FAIL wrap_%0d got=%h/%h exp=%h/%h", i, st_eq, if_eq.data_o,
                 exp_st(2, 4, 1, 1, 3, 1), q_eq[0]); end
      $display("wrap read %h", if_eq.data_o);
      void'(q_eq.pop_front());
      w = 16'($urandom);
      if_eq.data_i = w; q_eq.push_back(w);
      @(negedge clk);
    end
    if_eq.wr_valid_i = 0;
    while (q_eq.size() > 0) begin
      total++; if (if_eq.data_o !== q_eq[0]) begin bad++;
        $display("FAIL wrap_drain got=%h exp=%h", if_eq.data_o, q_eq[0]); end
      void'(q_eq.pop_front());
      @(negedge clk);
    end
    if_eq.rd_valid_i = 0;
    total++; if (st_eq !== exp_st(0, 4, 1, 1, 3, 1)) begin bad++;
      $display("FAIL wrap_empty got=%h exp=%h", st_eq, exp_st(0, 4, 1, 1, 3, 1)); end
  endtask

  // Random traffic on both downsizers (same stimulus, different ordering).
  task automatic test_random_down(int cycles);
    logic [31:0] w;
    logic wv, rv, fl, wacc, racc;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      total++; if (st_dn !== exp_st(q_dn.size(), 16, 4, 1, 15, 1)) begin bad++;
        $display("FAIL rnd_dn_status cyc=%0d got=%h exp=%h", c, st_dn, exp_st(q_dn.size(), 16, 4, 1, 15, 1)); end
      total++; if (st_dm !== exp_st(q_dm.size(), 16, 4, 1, 15, 1)) begin bad++;
        $display("FAIL rnd_dm_status cyc=%0d got=%h exp=%h", c, st_dm, exp_st(q_dm.size(), 16, 4, 1, 15, 1)); end
      if (q_dn.size() > 0) begin
        total++; if (if_dn.data_o !== q_dn[0]) begin bad++;
          $display("FAIL rnd_dn_data cyc=%0d got=%h exp=%h", c, if_dn.data_o, q_dn[0]); end
        total++; if (if_dm.data_o !== q_dm[0]) begin bad++;
          $display("FAIL rnd_dm_data cyc=%0d got=%h exp=%h", c, if_dm.data_o, q_dm[0]); end
      end
      w  = $urandom;
      wv = ($urandom_range(0, 3) < ((c < cycles / 2) ? 3 : 1));
      rv = ($urandom_range(0, 3) < ((c < cycles / 2) ? 1 : 3));
      fl = ($urandom_range(0, 39) == 0);
      if_dn.data_i = w; if_dn.wr_valid_i = wv; if_dn.rd_valid_i = rv; if_dn.flush_i = fl;
      if_dm.data_i = w; if_dm.wr_valid_i = wv; if_dm.rd_valid_i = rv; if_dm.flush_i = fl;
      wacc = !fl && wv && (16 - q_dn.size() >= 4);
      racc = !fl && rv && (q_dn.size() >= 1);
      if (fl) begin
        q_dn.delete(); q_dm.delete();
      end
      if (racc) begin
        void'(q_dn.pop_front()); void'(q_dm.pop_front());
      end
      if (wacc) begin
        for (int k = 0; k < 4; k++) begin
          q_dn.push_back(w[8*k +: 8]);
          q_dm.push_back(w[8*(3-k) +: 8]);
        end
      end
      if (fl || wacc || racc)
        $display("rnd_down cyc=%0d flush=%0b wr=%0b rd=%0b data=%h count_after=%0d",
                 c, fl, wacc, racc, w, q_dn.size());
    end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_random_up(int cycles);
    logic [7:0] b;
    logic wv, rv, fl, wacc, racc;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      total++; if (st_up !== exp_st(q_up.size(), 16, 1, 4, 15, 1)) begin bad++;
        $display("FAIL rnd_up_status cyc=%0d got=%h exp=%h", c, st_up, exp_st(q_up.size(), 16, 1, 4, 15, 1)); end
      if (q_up.size() >= 4) begin
        total++; if (if_up.data_o !== {q_up[3], q_up[2], q_up[1], q_up[0]}) begin bad++;
          $display("FAIL rnd_up_data cyc=%0d got=%h exp=%h", c, if_up.data_o,
                   {q_up[3], q_up[2], q_up[1], q_up[0]}); end
      end
      b  = 8'($urandom);
      wv = ($urandom_range(0, 3) < ((c < cycles / 2) ? 3 : 1));
      rv = ($urandom_range(0, 3) < ((c < cycles / 2) ? 1 : 3));
      fl = ($urandom_range(0, 39) == 0);
      if_up.data_i = b; if_up.wr_valid_i = wv; if_up.rd_valid_i = rv; if_up.flush_i = fl;
      wacc = !fl && wv && (16 - q_up.size() >= 1);
      racc = !fl && rv && (q_up.size() >= 4);
      if (fl) q_up.delete();
      if (racc) for (int k = 0; k < 4; k++) void'(q_up.pop_front());
      if (wacc) q_up.push_back(b);
      if (fl || wacc || racc)
        $display("rnd_up cyc=%0d flush=%0b wr=%0b rd=%0b data=%h count_after=%0d",
                 c, fl, wacc, racc, b, q_up.size());
    end
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    idle_all();
    rst_n = 1'b0;
    test_reset();
    test_downsize();
    test_upsize();
    test_full();
    test_flush();
    test_async_reset();
    test_wrap_equal();
    test_random_down(300);
    test_random_up(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so a stuck run still ends with a verdict.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
